regfile_bypass: RTL
===================

// Module: regfile_bypass
// PURPOSE
//  Parametrised register file; successor to the single 32-bit enabled register.
//  Holds DEPTH words of WIDTH bits, with one byte-masked write port and NUM_READ
//  combinational read ports. Optional hardwired-zero entry 0 and write-to-read bypass.
//  Sits between decode (register read) and writeback in the datapath.
// PARAMETERS
//  WIDTH     32  word width in bits; must be a multiple of 8
//  DEPTH     32  number of entries, >= 2; need not be a power of two
//  NUM_READ  2   number of independent read ports, >= 1
//  ZERO_REG  1   1: entry 0 reads as 0 and ignores writes
//  BYPASS    1   1: a read of the entry being written this cycle returns the new value
//  RESET_VAL 0   value loaded into every entry on reset (WIDTH bits)
// PORTS  (AW = $clog2(DEPTH), BW = WIDTH/8)
//  clk      in   1             single clock; all writes occur on its rising edge
//  reset    in   1             asynchronous, active-low: 0 = reset asserted
//  wr_en    in   1             write request
//  wr_addr  in   AW            write entry index
//  wr_mask  in   BW            byte enables; bit i covers wr_data[8i+7:8i]
//  wr_data  in   WIDTH         write data
//  rd_addr  in   NUM_READ*AW   read indices; port p uses bits [p*AW +: AW]
//  rd_data  out  NUM_READ*WIDTH read data; port p uses bits [p*WIDTH +: WIDTH]
// BEHAVIOUR
//  - Reset (reset==0): every entry takes RESET_VAL immediately, without waiting for a
//    clk edge, and holds it while reset stays low. Writes are blocked during reset.
//    rd_data reflects the reset contents combinationally; entry 0 reads 0 if ZERO_REG.
//  - Write: on the clk rising edge with reset==1, wr_en==1 and wr_addr<DEPTH, each
//    byte i with wr_mask[i]==1 takes wr_data byte i. Unmasked bytes keep their value.
//    Latency is 1 cycle: the stored value is visible after that edge.
//  - Writes are ignored when wr_en==0, when wr_mask==0, when wr_addr>=DEPTH, or
//    when ZERO_REG==1 and wr_addr==0.
//  - Read: purely combinational, with zero latency. Each port is independent, and
//    any number of ports may read the same entry.
//  - Out-of-range read (rd_addr>=DEPTH): returns 0. Entry 0 with ZERO_REG: returns 0.
//  - Bypass (BYPASS==1): if an accepted write is present this cycle and
//    rd_addr==wr_addr, then rd_data = (wr_data & M) | (stored & ~M).
//    M is wr_mask expanded to bit granularity. Bypass never applies to a suppressed
//    write, such as entry 0, out of range, or during reset.
//  - BYPASS==0: reads return the stored value; the new value appears after the edge.
//  - Reset releasing on the same edge as a write request: the write is dropped.
//    Writes are accepted from the first rising edge after reset reads 1.
//  - Reset asserted mid-write: reset wins, and the entry ends at RESET_VAL.
//  - There is no internal state beyond the storage array, so no FSM is needed.
// STRUCTURE
//  - Shared header regfile_defs.vh holds: the REGFILE_AW(d) macro ($clog2
//    helper), BYTE=8, and the default WIDTH/DEPTH used by the datapath.
//  - Sub-module reg_be: a WIDTH-bit register with async active-low reset, a
//    RESET_VAL parameter, per-byte enables and ports (q,d,clk,be,reset).
//    This is the byte-masked generalisation of the existing register.
//  - Top level: an address decoder producing per-entry byte enables, a generate
//    loop over DEPTH reg_be instances, and a generate loop over NUM_READ read
//    muxes, each with its bypass merge.
//  - Entry 0 is a constant, not an instance, when ZERO_REG==1.
// TESTING  (defaults unless noted)
//  1 Hold reset=0 for 10, then release, then read all 32 entries on both ports ->
//    every read returns 0. Repeat with RESET_VAL=32'hDEADBEEF -> entries 1..31
//    read DEADBEEF and entry 0 reads 0.
//  2 Write 88 to entry 5 with mask 4'hF, then write 89 to entry 5 with wr_en=0 ->
//    rd_addr=5 reads 88 after both writes. Write 42 to entry 0 -> entry 0 reads 0.
//  3 Preload entry 7 with 32'h11223344, then write 32'hAABBCCDD with mask 4'b0101
//    -> entry 7 reads 32'h11BB33DD.
//  4 BYPASS=1: in the same cycle as writing 651 to entry 9, port 1 reads entry 9
//    -> it returns 651 before the edge. BYPASS=0 -> it returns the old value until
//    the edge.
//  5 Pull reset low between edges while entry 3 holds 1 -> entry 3 reads
//    RESET_VAL with no clk edge. A write issued on the same edge that reset is
//    released -> dropped.
//  6 DEPTH=12: write to entry 13 (in range of AW=4) -> no entry changes, and
//    reading 13 returns 0. NUM_READ=4: all four ports read distinct entries
//    correctly in the same cycle.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_bypass_pkg                                         |
// | Description : Shared constants and helpers for the register file.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package regfile_bypass_pkg;

  // Bits per byte lane; word widths are whole multiples of this.
  localparam int BYTE = 8;

  // Default geometry used by the datapath.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  // Index width for a table of d entries; never narrower than one bit.
  function automatic int regfile_aw(input int d);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_bypass_reg_be.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reg_be                                                     |
// | Description : WIDTH-bit register with per-byte write enables and an      |
// |               asynchronous active-low reset to RESET_VAL.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module reg_be
  import regfile_bypass_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  output logic [WIDTH-1:0]      q,
  input  logic [WIDTH-1:0]      d,
  input  logic                  clk,
  input  logic [WIDTH/BYTE-1:0] be,
  input  logic                  reset
);

  localparam int c_bw = WIDTH / BYTE;

  for (genvar b = 0; b < c_bw; b++) begin : g_byte
    logic [BYTE-1:0] r_byte;

    // Each lane resets immediately and loads only when its enable is set.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_byte <= RESET_VAL[b*BYTE +: BYTE];
      end else if (be[b]) begin
        r_byte <= d[b*BYTE +: BYTE];
      end
    end

    assign q[b*BYTE +: BYTE] = r_byte;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_bypass                                             |
// | Description : DEPTH x WIDTH register file, one byte-masked write port,   |
// |               NUM_READ combinational read ports, optional hardwired      |
// |               zero entry and write-to-read bypass.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter int               NUM_READ  = 2,
  parameter int               ZERO_REG  = 1,
  parameter int               BYPASS    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              AW        = regfile_aw(DEPTH),
  localparam int              BW        = WIDTH / BYTE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [BW-1:0]             wr_mask,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*WIDTH-1:0] rd_data
);

  // One extra bit so DEPTH itself is representable for range compares.
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic             w_addr_ok;
  logic             w_zero_hit;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_bitmask;
  logic [WIDTH-1:0] w_q [DEPTH];

  // A write is real only outside reset, in range, with some byte enabled and
  // not aimed at the hardwired zero entry; the bypass keys off the same term.
  assign w_addr_ok  = ({1'b0, wr_addr} < c_depth);
  assign w_zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
  assign w_wr_ok    = reset && wr_en && (wr_mask != '0) && w_addr_ok && !w_zero_hit;

  // Byte enables expanded to bit granularity for the bypass merge.
  for (genvar b = 0; b < BW; b++) begin : g_mask
    assign w_bitmask[b*BYTE +: BYTE] = {BYTE{wr_mask[b]}};
  end

  // Storage: entry 0 collapses to a constant when hardwired to zero.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    if ((ZERO_REG != 0) && (e == 0)) begin : g_zero
      assign w_q[e] = '0;
    end else begin : g_reg
      localparam logic [AW-1:0] c_idx = AW'(e);
      logic [BW-1:0] w_be;

      // Address decode: this entry sees the write mask only when selected.
      assign w_be = (w_wr_ok && (wr_addr == c_idx)) ? wr_mask : '0;

      reg_be #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_reg (
        .q     (w_q[e]),
        .d     (wr_data),
        .clk   (clk),
        .be    (w_be),
        .reset (reset)
      );
    end
  end

  // Read ports: range-checked mux, then optional merge of the in-flight write.
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_stored;
    logic [WIDTH-1:0] w_merged;
    logic             w_hit;

    assign w_ra     = rd_addr[p*AW +: AW];
    assign w_stored = ({1'b0, w_ra} < c_depth) ? w_q[w_ra] : '0;
    assign w_merged = (wr_data & w_bitmask) | (w_stored & ~w_bitmask);
    assign w_hit    = (BYPASS != 0) && w_wr_ok && (w_ra == wr_addr);

    assign rd_data[p*WIDTH +: WIDTH] = w_hit ? w_merged : w_stored;
  end

endmodule
`default_nettype wire
